// File: rtl/spi_master_gen_if.sv
// Memory-mapped register bus for the SPI master.
//   i_memAddr    : register select within the 4-word window
//   i_memDataIn  : write data
//   i_memWrEn    : one-cycle write strobe
//   o_memDataOut : combinational read data for i_memAddr
// The master modport is the processor side, the slave modport the peripheral.
interface spi_master_gen_if;
    logic [1:0]  i_memAddr;
    logic [15:0] i_memDataIn;
    logic        i_memWrEn;
    logic [15:0] o_memDataOut;

    modport master (
        output i_memAddr,
        output i_memDataIn,
        output i_memWrEn,
        input  o_memDataOut
    );

    modport slave (
        input  i_memAddr,
        input  i_memDataIn,
        input  i_memWrEn,
        output o_memDataOut
    );
endinterface

// File: rtl/spi_master_gen.sv
// Parametrised SPI master (mode 0) for the storage chip, memory mapped.
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset
//   mem               : register bus (STATUS / LOCK / DATA / CFG)
//   i_spiMISO         : serial data from the chip
//   o_spiMOSI         : serial data to the chip (MSB of DATA)
//   o_spiSclk         : registered serial clock, idles low
//   o_spiEn           : chip enable, high while LOCK holds the key
//   o_spiHold         : high while no transfer is in progress
//   i_smIsBooted      : processor boot complete
//   i_smStartPause    : pause request from the state machine
//   o_smNowPaused     : pause acknowledge
module spi_master_gen #(
    parameter int          DATA_W = 8,
    parameter int          DIV_W  = 4,
    parameter logic [15:0] KEY    = 16'h2024
) (
    input  logic             i_clk,
    input  logic             i_rst,
    spi_master_gen_if.slave  mem,
    input  logic             i_spiMISO,
    output logic             o_spiMOSI,
    output logic             o_spiSclk,
    output logic             o_spiEn,
    output logic             o_spiHold,
    input  logic             i_smIsBooted,
    input  logic             i_smStartPause,
    output logic             o_smNowPaused
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    logic [1:0]        state_reg;
    logic [15:0]       lock_reg;
    logic [DATA_W-1:0] data_reg;
    logic [DIV_W-1:0]  div_reg;
    logic [DIV_W-1:0]  dcnt_reg;
    logic [4:0]        bcnt_reg;
    logic              sample_reg;
    logic              sclk_reg;
    logic              done_reg;
    logic              abort_reg;
    logic              pause_reg;

    logic              idle;
    logic              unlocked;
    logic              do_pause;
    logic              start;
    logic              wr_status;
    logic              wr_lock;
    logic              wr_data;
    logic              wr_cfg;
    logic [DATA_W-1:0] shifted;
    logic [15:0]       rd_data;

    assign idle      = (state_reg == ST_IDLE);
    assign unlocked  = (lock_reg == KEY);
    assign do_pause  = ~i_smIsBooted | i_smStartPause | pause_reg;

    assign wr_status = mem.i_memWrEn && (mem.i_memAddr == 2'b00);
    assign wr_lock   = mem.i_memWrEn && (mem.i_memAddr == 2'b01);
    assign wr_data   = mem.i_memWrEn && (mem.i_memAddr == 2'b10);
    assign wr_cfg    = mem.i_memWrEn && (mem.i_memAddr == 2'b11);
    assign start     = wr_data && idle && unlocked && !do_pause;

    // One-bit transfers have nothing to shift: the sampled bit is the word.
    generate
        if (DATA_W == 1) begin : g_shift_w1
            assign shifted = sample_reg;
        end else begin : g_shift_wn
            assign shifted = {data_reg[DATA_W-2:0], sample_reg};
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg  <= ST_IDLE;
            lock_reg   <= '0;
            data_reg   <= '0;
            div_reg    <= '0;
            dcnt_reg   <= '0;
            bcnt_reg   <= '0;
            sample_reg <= 1'b0;
            sclk_reg   <= 1'b0;
            done_reg   <= 1'b0;
            abort_reg  <= 1'b0;
            pause_reg  <= 1'b0;
        end else begin
            pause_reg <= i_smStartPause & idle;

            // Clears come first so a same-cycle set below overrides them.
            if (wr_status) begin
                if (mem.i_memDataIn[13]) done_reg  <= 1'b0;
                if (mem.i_memDataIn[12]) abort_reg <= 1'b0;
            end
            if (wr_lock) begin
                lock_reg <= mem.i_memDataIn;
            end
            if (wr_cfg && idle) begin
                div_reg <= mem.i_memDataIn[DIV_W-1:0];
            end

            if (!idle && !unlocked) begin
                // Relocked mid-transfer: drop everything, keep partial DATA.
                state_reg <= ST_IDLE;
                sclk_reg  <= 1'b0;
                abort_reg <= 1'b1;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start) begin
                            data_reg  <= mem.i_memDataIn[DATA_W-1:0];
                            state_reg <= ST_LOW;
                            dcnt_reg  <= '0;
                            bcnt_reg  <= '0;
                            sclk_reg  <= 1'b0;
                        end
                    end
                    ST_LOW: begin
                        if (dcnt_reg == div_reg) begin
                            sample_reg <= i_spiMISO;
                            sclk_reg   <= 1'b1;
                            dcnt_reg   <= '0;
                            state_reg  <= ST_HIGH;
                        end else begin
                            dcnt_reg <= dcnt_reg + 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if (dcnt_reg == div_reg) begin
                            // MOSI (DATA MSB) moves only here, on the falling edge.
                            data_reg <= shifted;
                            sclk_reg <= 1'b0;
                            dcnt_reg <= '0;
                            bcnt_reg <= bcnt_reg + 1'b1;
                            if (bcnt_reg == 5'(DATA_W - 1)) begin
                                state_reg <= ST_IDLE;
                                done_reg  <= 1'b1;
                            end else begin
                                state_reg <= ST_LOW;
                            end
                        end else begin
                            dcnt_reg <= dcnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        sclk_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (mem.i_memAddr)
            2'b00:   rd_data[15:12] = {idle, unlocked, done_reg, abort_reg};
            2'b01:   rd_data = lock_reg;
            2'b10:   rd_data[DATA_W-1:0] = data_reg;
            default: rd_data[DIV_W-1:0] = div_reg;
        endcase
    end

    assign mem.o_memDataOut = rd_data;
    assign o_spiMOSI        = data_reg[DATA_W-1];
    assign o_spiSclk        = sclk_reg;
    assign o_spiEn          = unlocked;
    assign o_spiHold        = idle;
    assign o_smNowPaused    = pause_reg;

endmodule

// File: doc/spi_master_gen.md
Name: spi_master_gen

Overview:
- Parametrised successor to the memory-mapped storage-chip SPI controller.
- Adds generic transfer width, a programmable SCLK divider with an explicit SCLK output (SPI mode 0), a sticky done flag, and an abort-on-relock flag.
- Retains the lock/key gating and the boot/pause handshake with the state machine.
- Sits on the memory map at a 4-word window; drives the storage chip's serial pins.

Parameters:
- DATA_W, 8, bits per transfer (legal 1..16); data register width.
- DIV_W, 4, width of the SCLK divider field (legal 1..14).
- KEY, 16'h2024, lock value that enables the SPI.

Ports:
- i_clk  input  1  system clock; all state updates on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_memAddr  input  2  register select within window.
- i_memDataIn  input  16  write data.
- i_memWrEn  input  1  write strobe, one cycle per write.
- o_memDataOut  output  16  combinational read data for i_memAddr.
- i_spiMISO  input  1  serial data from chip.
- o_spiMOSI  output  1  serial data to chip; = DATA[DATA_W-1].
- o_spiSclk  output  1  serial clock, registered; idles low.
- o_spiEn  output  1  chip select active; = unlocked.
- o_spiHold  output  1  high while idle (no transfer in progress).
- i_smIsBooted  input  1  processor boot complete.
- i_smStartPause  input  1  request that the SPI pause.
- o_smNowPaused  output  1  SPI paused acknowledgement.

Behaviour:

Reset: synchronous, active-high.
- On i_rst: LOCK, DATA, CFG, DONE, ABORT, PAUSE are 0; FSM is IDLE; o_spiSclk is 0.
- Resulting outputs: o_spiEn=0, o_spiHold=1, o_smNowPaused=0, o_spiMOSI=0.

Register map:
- 00 STATUS: bit15 idle, bit14 unlocked, bit13 DONE, bit12 ABORT, others 0. Write with bit13=1 clears DONE; write with bit12=1 clears ABORT; other bits ignored.
- 01 LOCK: 16-bit read/write. unlocked = (LOCK==KEY).
- 10 DATA: read returns DATA zero-extended to 16. A write loads i_memDataIn[DATA_W-1:0] and starts a transfer only when idle & unlocked & ~doPause; otherwise the write is ignored entirely.
- 11 CFG: bits[DIV_W-1:0] = DIV, others read 0. A write is ignored while busy.

doPause = ~i_smIsBooted | i_smStartPause | PAUSE.

FSM states: IDLE, LOW, HIGH. Divider counter dcnt (DIV_W bits); bit counter bcnt (5 bits).
- IDLE -> LOW on a start; dcnt=0, bcnt=0, sclk=0.
- LOW: dcnt increments. When dcnt==DIV: capture MISO into sampleBit, set sclk=1, dcnt=0, go to HIGH.
- HIGH: dcnt increments. When dcnt==DIV: DATA <= {DATA[DATA_W-2:0], sampleBit}, sclk=0, dcnt=0, bcnt++.
  - If bcnt==DATA_W-1: go to IDLE and set DONE.
  - Else go to LOW.
- Transfer length is exactly 2*DATA_W*(DIV+1) cycles from the start-write edge to idle.
- MOSI changes only on SCLK falling edges; it never changes in the cycle SCLK rises.
- DATA_W=1: the shift reduces to DATA <= sampleBit.

Abort:
- If unlocked deasserts while not IDLE (any LOCK write of a non-key value), the next edge goes to IDLE.
- On abort: sclk=0, ABORT=1, DONE unchanged, DATA keeps its partially shifted value.

Simultaneous events:
- Transfer completion and a STATUS write clearing DONE in the same cycle: set wins (DONE=1).
- Same rule applies to abort vs. clearing ABORT.

Pause: PAUSE <= i_smStartPause & idle.
- A pause requested mid-transfer is acknowledged only after the transfer completes.
- o_smNowPaused = PAUSE.

Test Plan:
- Lock handshake: write 01=16'h2024, then 10=8'hA5 with DIV=0 and MISO tied to the pattern 8'h3C → SCLK shows 8 pulses, each 1 cycle high / 1 cycle low. MOSI bits are 1,0,1,0,0,1,0,1. Idle reasserts 16 cycles after the write. DATA reads 16'h003C; STATUS reads 16'hE000.
- Divider: write CFG=3, then start a transfer → SCLK half-period is 4 cycles; total 64 cycles; the CFG write issued mid-transfer is ignored (reads 3).
- Locked / not-booted start: write DATA with LOCK=0, or with i_smIsBooted=0 → no SCLK activity; DATA unchanged; status idle=1.
- Abort: mid-transfer (after 3 bits), write LOCK=0 → next cycle idle=1, SCLK=0, ABORT=1, DONE=0, o_spiEn=0. Then write STATUS=16'h1000 → ABORT=0.
- Pause: assert i_smStartPause during a transfer → o_smNowPaused stays 0 until the cycle after idle, then 1. A DATA write while paused is ignored.
- Reset mid-transfer: assert i_rst during HIGH → next edge yields IDLE, SCLK=0, LOCK/DATA/CFG/DONE=0. Repeat with DATA_W=16, KEY=16'h1234 to cover parameters.
